pr_alloc: RTL and testbench

- Physical-register allocation stage of rename, directly upstream of the freelist pointer manager.
- Owns the 64-entry freelist tag RAM and takes a 4-wide decode group. Counts destination writes, checks the freelist has enough room, and reads one free physical-register tag per destination.
- Drives the pointer manager's allocate count and pause.
- Writes PR tags released at commit back into the RAM.
- Registers the allocated tags into a valid/ready output stage that feeds the RAT/rename stage.

---
 rtl/pr_alloc_pkg.sv | 16 +
 rtl/pr_alloc_fl_tag_ram.sv | 26 ++
 rtl/pr_alloc.sv | 64 ++++++
 tb/tb_pr_alloc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pr_alloc_pkg.sv
// pr_alloc_pkg: shared widths, freelist geometry and popcount helpers for rename allocation
package pr_alloc_pkg;
   localparam int DECODE_W = 4;
   localparam int FREE_W   = 2;
   localparam int PR_W     = 7;
   localparam int FL_DEPTH = 64;
   localparam int FL_PTR_W = 7;
   localparam int FL_IDX_W = 6;
   localparam int FL_BASE  = 32;
   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction
   function automatic logic [1:0] popcnt2(input logic [1:0] v);
      return 2'(v[0]) + 2'(v[1]);
   endfunction
endpackage

// File: rtl/pr_alloc_fl_tag_ram.sv
// fl_tag_ram: 64x7 freelist tag store, four async reads, two lane-packed commit writes
module fl_tag_ram
   import pr_alloc_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [FL_IDX_W-1:0]      rd_idx [DECODE_W],
   output logic [PR_W-1:0]          rd_tag [DECODE_W],
   input  logic [FREE_W-1:0]        free_valid,
   input  logic [FREE_W*PR_W-1:0]   free_preg
);
   logic [PR_W-1:0]     mem [FL_DEPTH];
   logic [FL_IDX_W-1:0] wr_idx;
   always_comb
      for (int j = 0; j < DECODE_W; j++) rd_tag[j] = mem[rd_idx[j]];
   // lane 1 lands right after lane 0 only when lane 0 is valid
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_idx <= '0;
         for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PR_W'(FL_BASE + i);
      end else begin
         if (free_valid[0]) mem[wr_idx] <= free_preg[PR_W-1:0];
         if (free_valid[1]) mem[wr_idx + FL_IDX_W'(free_valid[0])] <= free_preg[2*PR_W-1:PR_W];
         wr_idx <= wr_idx + FL_IDX_W'(popcnt2(free_valid));
      end
endmodule

// File: rtl/pr_alloc.sv
// pr_alloc: rename-stage physical register allocation from the freelist with a registered output stage
module pr_alloc
   import pr_alloc_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_stage4,
   input  logic [DECODE_W-1:0]      in_valid,
   input  logic [DECODE_W-1:0]      in_has_dest,
   output logic                     in_ready,
   input  logic [FL_PTR_W-1:0]      rd_ptr,
   input  logic [FL_PTR_W-1:0]      freelist_room,
   output logic [2:0]               PR_num_need,
   output logic                     stage4_pause,
   input  logic [FREE_W-1:0]        free_valid,
   input  logic [FREE_W*PR_W-1:0]   free_preg,
   output logic [1:0]               PR_num_wrback,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DECODE_W-1:0]      out_slot_valid,
   output logic [DECODE_W-1:0]      out_preg_valid,
   output logic [DECODE_W*PR_W-1:0] out_preg
);
   logic [DECODE_W-1:0] dmask;
   logic [2:0]          need;
   logic                fire;
   logic [FL_IDX_W-1:0] rd_idx [DECODE_W];
   logic [PR_W-1:0]     rd_tag [DECODE_W];
   logic                unused_ptr_msb;
   assign unused_ptr_msb = rd_ptr[FL_PTR_W-1];
   assign dmask         = in_valid & in_has_dest;
   assign need          = popcnt4(dmask);
   assign in_ready      = !flush_stage4 && (!out_valid || out_ready) && (FL_PTR_W'(need) <= freelist_room);
   assign fire          = in_ready && (in_valid != '0);
   assign PR_num_need   = fire ? need : 3'd0;
   assign stage4_pause  = !fire;
   assign PR_num_wrback = popcnt2(free_valid);
   // each dest slot reads the entry offset by the number of dest slots below it
   always_comb
      for (int j = 0; j < DECODE_W; j++)
         rd_idx[j] = rd_ptr[FL_IDX_W-1:0] + FL_IDX_W'(popcnt4(dmask & ((4'b1 << j) - 4'b1)));
   fl_tag_ram u_ram (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (rd_idx),
      .rd_tag     (rd_tag),
      .free_valid (free_valid),
      .free_preg  (free_preg)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid      <= 1'b0;
         out_slot_valid <= '0;
         out_preg_valid <= '0;
         out_preg       <= '0;
      end else if (fire) begin
         out_valid      <= 1'b1;
         out_slot_valid <= in_valid;
         out_preg_valid <= dmask;
         for (int j = 0; j < DECODE_W; j++) out_preg[j*PR_W +: PR_W] <= dmask[j] ? rd_tag[j] : '0;
      end else if (flush_stage4 || out_ready) begin
         out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_pr_alloc.sv
// tb_pr_alloc: directed-vector self-checking bench for pr_alloc
module tb_pr_alloc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_stage4 = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_has_dest = '0;
   logic        in_ready;
   logic [6:0]  rd_ptr = '0;
   logic [6:0]  freelist_room = 7'd64;
   logic [2:0]  PR_num_need;
   logic        stage4_pause;
   logic [1:0]  free_valid = '0;
   logic [13:0] free_preg = '0;
   logic [1:0]  PR_num_wrback;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_slot_valid;
   logic [3:0]  out_preg_valid;
   logic [27:0] out_preg;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   pr_alloc dut (
      .clk            (clk),
      .rst            (rst),
      .flush_stage4   (flush_stage4),
      .in_valid       (in_valid),
      .in_has_dest    (in_has_dest),
      .in_ready       (in_ready),
      .rd_ptr         (rd_ptr),
      .freelist_room  (freelist_room),
      .PR_num_need    (PR_num_need),
      .stage4_pause   (stage4_pause),
      .free_valid     (free_valid),
      .free_preg      (free_preg),
      .PR_num_wrback  (PR_num_wrback),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_slot_valid (out_slot_valid),
      .out_preg_valid (out_preg_valid),
      .out_preg       (out_preg)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   function automatic logic [27:0] pg(input int t3, input int t2, input int t1, input int t0);
      return {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
   endfunction
   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_preg", 32'(out_preg), 0);
      chk("rst_slot_valid", 32'(out_slot_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_pause", 32'(stage4_pause), 1);
      chk("rst_wrback", 32'(PR_num_wrback), 0);
      @(negedge clk);
      in_valid = 4'b1111; in_has_dest = 4'b1111; rd_ptr = 7'd0;
      #1;
      chk("g1_in_ready", 32'(in_ready), 1);
      chk("g1_need", 32'(PR_num_need), 4);
      chk("g1_pause", 32'(stage4_pause), 0);
      step();
      chk("g1_out_valid", 32'(out_valid), 1);
      chk("g1_out_preg", 32'(out_preg), 32'(pg(35, 34, 33, 32)));
      chk("g1_preg_valid", 32'(out_preg_valid), 32'hf);
      chk("g1_slot_valid", 32'(out_slot_valid), 32'hf);
      rd_ptr = 7'd4; in_has_dest = 4'b0101;
      #1;
      chk("g2_in_ready", 32'(in_ready), 1);
      chk("g2_need", 32'(PR_num_need), 2);
      step();
      chk("g2_out_preg", 32'(out_preg), 32'(pg(0, 37, 0, 36)));
      chk("g2_preg_valid", 32'(out_preg_valid), 32'h5);
      freelist_room = 7'd1; in_has_dest = 4'b0011;
      #1;
      chk("room1_in_ready", 32'(in_ready), 0);
      chk("room1_need", 32'(PR_num_need), 0);
      chk("room1_pause", 32'(stage4_pause), 1);
      step();
      chk("room1_out_valid", 32'(out_valid), 0);
      freelist_room = 7'd2;
      #1;
      chk("room2_in_ready", 32'(in_ready), 1);
      chk("room2_need", 32'(PR_num_need), 2);
      step();
      chk("room2_out_valid", 32'(out_valid), 1);
      chk("room2_out_preg", 32'(out_preg), 32'(pg(0, 0, 37, 36)));
      out_ready = 1'b0; freelist_room = 7'd64; rd_ptr = 7'd8; in_has_dest = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 0);
         step();
         chk("stall_out_valid", 32'(out_valid), 1);
         chk("stall_out_preg", 32'(out_preg), 32'(pg(0, 0, 37, 36)));
         chk("stall_preg_valid", 32'(out_preg_valid), 32'h3);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", 32'(in_ready), 1);
      step();
      chk("unstall_out_preg", 32'(out_preg), 32'(pg(43, 42, 41, 40)));
      in_valid = 4'b0001; in_has_dest = 4'b0000; freelist_room = 7'd0;
      #1;
      chk("empty_in_ready", 32'(in_ready), 1);
      chk("empty_need", 32'(PR_num_need), 0);
      step();
      chk("empty_out_valid", 32'(out_valid), 1);
      chk("empty_slot_valid", 32'(out_slot_valid), 32'h1);
      chk("empty_preg_valid", 32'(out_preg_valid), 0);
      chk("empty_out_preg", 32'(out_preg), 0);
      in_valid = 4'b0000; freelist_room = 7'd64;
      free_valid = 2'b11; free_preg = {7'd7, 7'd5};
      #1;
      chk("free2_wrback", 32'(PR_num_wrback), 2);
      chk("idle_pause", 32'(stage4_pause), 1);
      step();
      chk("drain_out_valid", 32'(out_valid), 0);
      free_valid = 2'b00;
      in_valid = 4'b1111; in_has_dest = 4'b1111; rd_ptr = 7'd62;
      step();
      chk("wrap_out_preg", 32'(out_preg), 32'(pg(7, 5, 95, 94)));
      flush_stage4 = 1'b1; out_ready = 1'b0;
      free_valid = 2'b01; free_preg = {7'd0, 7'd9};
      #1;
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_need", 32'(PR_num_need), 0);
      chk("flush_pause", 32'(stage4_pause), 1);
      chk("flush_wrback", 32'(PR_num_wrback), 1);
      step();
      chk("flush_out_valid", 32'(out_valid), 0);
      flush_stage4 = 1'b0; out_ready = 1'b1;
      free_valid = 2'b10; free_preg = {7'd11, 7'd0};
      rd_ptr = 7'd1; in_has_dest = 4'b0011;
      #1;
      chk("lane1_wrback", 32'(PR_num_wrback), 1);
      step();
      chk("flushfree_out_preg", 32'(out_preg), 32'(pg(0, 0, 9, 7)));
      free_valid = 2'b00; rd_ptr = 7'd2;
      step();
      chk("lane1_out_preg", 32'(out_preg), 32'(pg(0, 0, 11, 9)));
      chk("lane1_out_valid", 32'(out_valid), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
